// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register bank through its debug read port and
// streams a header byte followed by every register, MSB first, over a
// valid/ready byte interface.
//   clk, rst_n          clock / asynchronous active-low reset
//   start, abort        dump request (IDLE only) / synchronous cancel
//   dbg_addr, dbg_rdata combinational debug read port of the register bank
//   out_data, out_valid, out_ready   byte stream towards the debug link
//   busy, done          dump in progress / one-cycle completion pulse
module reg_dump_reader #(
    parameter int unsigned WIDTH_B  = 32,
    parameter int unsigned ADDR_B   = 5,
    parameter int unsigned NUM_REGS = 2 ** ADDR_B,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [ADDR_B-1:0]   dbg_addr,
    input  logic [WIDTH_B-1:0]  dbg_rdata,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BYTES  = WIDTH_B / 8;
    localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [ADDR_B-1:0] LAST_ADDR = ADDR_B'(NUM_REGS - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_q,     state_d;
    logic [ADDR_B-1:0]  addr_cnt_q,  addr_cnt_d;
    logic [BCNT_W-1:0]  byte_cnt_q,  byte_cnt_d;
    logic [WIDTH_B-1:0] shift_q,     shift_d;
    logic [7:0]         out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;

    // Next byte after a transfer; computed on a full-width value so BYTES=1 still elaborates.
    logic [WIDTH_B-1:0] shift_next;
    assign shift_next = shift_q << 8;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_HDR;
                    busy_d      = 1'b1;
                    addr_cnt_d  = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = HEADER;
                end
            end
            S_HDR: begin
                if (out_ready) begin
                    state_d     = S_LOAD;
                    out_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                // Only sampling point of the bank for this register.
                state_d     = S_SEND;
                shift_d     = dbg_rdata;
                byte_cnt_d  = '0;
                out_data_d  = dbg_rdata[WIDTH_B-1 -: 8];
                out_valid_d = 1'b1;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (byte_cnt_q != LAST_BYTE) begin
                        shift_d    = shift_next;
                        out_data_d = shift_next[WIDTH_B-1 -: 8];
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end else if (addr_cnt_q == LAST_ADDR) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d     = S_LOAD;
                        out_valid_d = 1'b0;
                        addr_cnt_d  = addr_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase

        // Abort wins over any same-edge transfer in the active states.
        if (abort && (state_q == S_HDR || state_q == S_LOAD || state_q == S_SEND)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            addr_cnt_d  = '0;
            byte_cnt_d  = '0;
        end
    end

    assign dbg_addr  = addr_cnt_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: the driver pushes expected stream
// bytes, a negedge monitor pops and compares on every transfer.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [31:0] bank     [32];
    logic [31:0] exp_bank [32];

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int exp_done  = 0;

    bit       stalled  = 1'b0;
    bit       prev_cut = 1'b0;
    logic [7:0] stall_byte = 8'h00;

    always #5 clk = ~clk;

    assign dbg_rdata = bank[dbg_addr];

    reg_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected stream for one full dump, taken from exp_bank.
    function automatic void push_dump();
        got_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 32; i++) begin
            for (int b = 3; b >= 0; b--) begin
                logic [31:0] w;
                w = exp_bank[i];
                exp_q.push_back(w[8*b +: 8]);
            end
        end
    endfunction

    // Monitor: compare each transferred byte, check stall stability and done pulses.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (stalled && !prev_cut)
                check("stall_hold", 32'(out_data), 32'(stall_byte));
            if (out_ready) begin
                got_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got %h expected no byte at %0t", out_data, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("stream_byte", 32'(out_data), 32'(e));
                end
                stalled = 1'b0;
            end else begin
                stalled    = 1'b1;
                stall_byte = out_data;
            end
        end else begin
            if (stalled && !prev_cut && rst_n)
                check("valid_drop", 32'(out_valid), 32'd1);
            stalled = 1'b0;
        end
        if (rst_n && done) begin
            done_seen++;
            check("done_sb_empty", 32'(exp_q.size()), 32'd0);
        end
        prev_cut = abort || !rst_n;
    end

    // One dump: mode 0 = out_ready high, mode 1 = ready one cycle in three.
    task automatic run_dump(input int mode, input bit hold_start, input bit do_writes,
                            input int exp_cycle);
        int done_at;
        done_at = 0;
        push_dump();
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = (mode == 0);
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (mode == 1) out_ready = ((cyc % 3) == 0);
            if (do_writes && cyc == 18) begin
                bank[3]  = 32'hCAFEF00D;
                bank[10] = 32'h0BADF00D;
            end
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_cycle1", 32'(busy), 32'd1);
                check("valid_cycle1", 32'(out_valid), 32'd1);
            end
            if (do_writes && cyc == 17) check("dbg_addr_load3", 32'(dbg_addr), 32'd3);
            if (done) begin
                done_at = cyc;
                check("busy_in_done", 32'(busy), 32'd0);
            end
            @(posedge clk); #1;
            if (done_at != 0) begin
                start = 1'b0;
                break;
            end
        end
        exp_done++;
        check("done_seen_in_time", 32'(done_at != 0), 32'd1);
        if (exp_cycle != 0) check("done_cycle", 32'(done_at), 32'(exp_cycle));
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("stream_len", 32'(got_q.size()), 32'd129);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_addr"},  32'(dbg_addr),  32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            bank[i]     = 32'h11223300 + 32'(i);
            exp_bank[i] = bank[i];
        end
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #12;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: plain dump with ready stuck high.
        run_dump(0, 1'b0, 1'b0, 162);
        check("t1_byte1", 32'(got_q[1]), 32'h11);
        check("t1_byte4", 32'(got_q[4]), 32'h00);
        check("t1_last",  32'(got_q[128]), 32'h1F);

        // 2: backpressure, r5 = DEADBEEF.
        bank[5] = 32'hDEADBEEF; exp_bank[5] = 32'hDEADBEEF;
        run_dump(1, 1'b0, 1'b0, 0);
        check("t2_b21", 32'(got_q[21]), 32'hDE);
        check("t2_b22", 32'(got_q[22]), 32'hAD);
        check("t2_b23", 32'(got_q[23]), 32'hBE);
        check("t2_b24", 32'(got_q[24]), 32'hEF);
        bank[5] = 32'h11223305; exp_bank[5] = 32'h11223305;

        // 3: start held through busy and DONE, then a fresh dump.
        run_dump(0, 1'b1, 1'b0, 162);
        repeat (3) begin
            @(negedge clk);
            check("t3_no_restart", 32'(busy), 32'd0);
        end
        check("t3_done_count", 32'(done_seen), 32'(exp_done));
        run_dump(0, 1'b0, 1'b0, 162);

        // 4: r3 written after its LOAD, r10 before its LOAD.
        exp_bank[10] = 32'h0BADF00D;
        run_dump(0, 1'b0, 1'b1, 162);
        check("t4_r3_b0",  32'(got_q[13]), 32'h11);
        check("t4_r3_b3",  32'(got_q[16]), 32'h03);
        check("t4_r10_b0", 32'(got_q[41]), 32'h0B);
        check("t4_r10_b3", 32'(got_q[44]), 32'h0D);
        bank[3]  = 32'h11223303;
        bank[10] = 32'h1122330A; exp_bank[10] = 32'h1122330A;

        // 5: abort while byte 50 is presented.
        push_dump();
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            if (got_q.size() == 50) break;
        end
        check("t5_reached_50", 32'(got_q.size()), 32'd50);
        #1;
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("t5_valid_before", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t5_valid_after", 32'(out_valid), 32'd0);
        check("t5_busy_after",  32'(busy), 32'd0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("t5_no_done", 32'(done_seen), 32'(exp_done));
        run_dump(0, 1'b0, 1'b0, 162);

        // 6a: asynchronous reset in HDR.
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        #2;
        check("t6_hdr_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_hdr_rst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_hdr_idle_valid", 32'(out_valid), 32'd0);
        check("t6_hdr_idle_busy",  32'(busy), 32'd0);

        // 6b: asynchronous reset in SEND of register 1.
        push_dump();
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("t6_send_addr", 32'(dbg_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_send_rst");
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_send_idle_valid", 32'(out_valid), 32'd0);
        check("t6_send_idle_busy",  32'(busy), 32'd0);
        check("final_done_count", 32'(done_seen), 32'(exp_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
